// File: rtl/fixed_mac_dot_seq.sv
// Dot-product sequencer for one fixed-point MAC. It clears the MAC, streams VECTOR_LEN operand pairs, waits a settle cycle, then holds the result.
// Define FIXED_MAC_DOT_SEQ_BIAS_EN to add a 'bias' port that seeds the accumulator in place of zero.
module fixed_mac_dot_seq #(
    parameter int DATA_WIDTH = 16,
    parameter int VECTOR_LEN = 4
) (
    input  logic                  core_clk,
    input  logic                  resetn,
    input  logic [DATA_WIDTH-1:0] data_in_a,
    input  logic [DATA_WIDTH-1:0] data_in_b,
    input  logic                  data_in_valid,
    output logic                  data_in_ready,
    output logic [DATA_WIDTH-1:0] mac_a,
    output logic [DATA_WIDTH-1:0] mac_b,
    output logic                  mac_in_valid,
    input  logic                  mac_in_ready,
    output logic                  mac_overwrite,
    output logic [DATA_WIDTH-1:0] mac_overwrite_data,
    input  logic [DATA_WIDTH-1:0] mac_accumulator,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_out_valid,
    input  logic                  data_out_ready
`ifdef FIXED_MAC_DOT_SEQ_BIAS_EN
    ,
    input  logic [DATA_WIDTH-1:0] bias
`endif
);

    localparam int CNT_W = (VECTOR_LEN > 1) ? $clog2(VECTOR_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(VECTOR_LEN - 1);

    typedef enum logic [1:0] {CLEAR, STREAM, SETTLE, OUT} state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] count;
    logic             in_hs;

    assign in_hs = (state == STREAM) && data_in_valid && mac_in_ready;

    always_ff @(posedge core_clk or negedge resetn) begin
        if (!resetn) begin
            state <= CLEAR;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            CLEAR:   state_next = STREAM;
            STREAM:  if (in_hs && (count == LAST_IDX)) state_next = SETTLE;
            SETTLE:  state_next = OUT;
            OUT:     if (data_out_valid && data_out_ready) state_next = CLEAR;
            default: state_next = CLEAR;
        endcase
    end

    // The result is captured at the end of SETTLE, one cycle after the last
    // MAC update, so the accumulator register has already absorbed it.
    always_ff @(posedge core_clk or negedge resetn) begin
        if (!resetn) begin
            count          <= '0;
            data_out       <= '0;
            data_out_valid <= 1'b0;
        end else begin
            case (state)
                CLEAR:  count <= '0;
                STREAM: if (in_hs) count <= count + 1'b1;
                SETTLE: begin
                    data_out       <= mac_accumulator;
                    data_out_valid <= 1'b1;
                end
                OUT:    if (data_out_ready) data_out_valid <= 1'b0;
                default: ;
            endcase
        end
    end

    always_comb begin
        mac_a              = '0;
        mac_b              = '0;
        mac_in_valid       = 1'b0;
        data_in_ready      = 1'b0;
        mac_overwrite      = 1'b0;
        mac_overwrite_data = '0;
        case (state)
            CLEAR: begin
                mac_overwrite = 1'b1;
`ifdef FIXED_MAC_DOT_SEQ_BIAS_EN
                mac_overwrite_data = bias;
`else
                mac_overwrite_data = '0;
`endif
            end
            STREAM: begin
                mac_a         = data_in_a;
                mac_b         = data_in_b;
                mac_in_valid  = data_in_valid;
                data_in_ready = mac_in_ready;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_fixed_mac_dot_seq.sv
// Self-checking bench for fixed_mac_dot_seq: a behavioural MAC per instance and a result scoreboard.
// Covers VECTOR_LEN=4 and VECTOR_LEN=1 instances; the bias test runs only with FIXED_MAC_DOT_SEQ_BIAS_EN.
module tb_fixed_mac_dot_seq;

    localparam int DW = 16;
    localparam int VL = 4;

    logic          core_clk = 1'b0;
    logic          resetn = 1'b0;
    logic [DW-1:0] data_in_a = '0;
    logic [DW-1:0] data_in_b = '0;
    logic          data_in_valid = 1'b0;
    logic          data_in_ready;
    logic [DW-1:0] mac_a;
    logic [DW-1:0] mac_b;
    logic          mac_in_valid;
    logic          mac_in_ready = 1'b1;
    logic          mac_overwrite;
    logic [DW-1:0] mac_overwrite_data;
    logic [DW-1:0] mac_accumulator = '0;
    logic [DW-1:0] data_out;
    logic          data_out_valid;
    logic          data_out_ready = 1'b1;
    logic [DW-1:0] bias_val = '0;

    logic [DW-1:0] in_a_1 = '0;
    logic [DW-1:0] in_b_1 = '0;
    logic          in_valid_1 = 1'b0;
    logic          in_ready_1;
    logic [DW-1:0] mac_a_1;
    logic [DW-1:0] mac_b_1;
    logic          mac_in_valid_1;
    logic          mac_overwrite_1;
    logic [DW-1:0] mac_overwrite_data_1;
    logic [DW-1:0] mac_acc_1 = '0;
    logic [DW-1:0] out_1;
    logic          out_valid_1;
    logic [DW-1:0] bias_1 = '0;

    int            checks = 0;
    int            failures = 0;
    int            cyc = 0;
    int            out_count = 0;
    int            mac_hs = 0;
    int            mac_hs_1 = 0;
    int            hs_cyc[16];
    logic [DW-1:0] op_a[16];
    logic [DW-1:0] op_b[16];
    logic [DW-1:0] exp_q[$];
    int            rise_q[$];
    int            ovw_q[$];
    logic [DW-1:0] sb_exp;
    logic          prev_valid = 1'b0;

    fixed_mac_dot_seq #(.DATA_WIDTH(DW), .VECTOR_LEN(VL)) dut (
        .core_clk           (core_clk),
        .resetn             (resetn),
        .data_in_a          (data_in_a),
        .data_in_b          (data_in_b),
        .data_in_valid      (data_in_valid),
        .data_in_ready      (data_in_ready),
        .mac_a              (mac_a),
        .mac_b              (mac_b),
        .mac_in_valid       (mac_in_valid),
        .mac_in_ready       (mac_in_ready),
        .mac_overwrite      (mac_overwrite),
        .mac_overwrite_data (mac_overwrite_data),
        .mac_accumulator    (mac_accumulator),
        .data_out           (data_out),
        .data_out_valid     (data_out_valid),
        .data_out_ready     (data_out_ready)
`ifdef FIXED_MAC_DOT_SEQ_BIAS_EN
        ,
        .bias               (bias_val)
`endif
    );

    fixed_mac_dot_seq #(.DATA_WIDTH(DW), .VECTOR_LEN(1)) dut1 (
        .core_clk           (core_clk),
        .resetn             (resetn),
        .data_in_a          (in_a_1),
        .data_in_b          (in_b_1),
        .data_in_valid      (in_valid_1),
        .data_in_ready      (in_ready_1),
        .mac_a              (mac_a_1),
        .mac_b              (mac_b_1),
        .mac_in_valid       (mac_in_valid_1),
        .mac_in_ready       (1'b1),
        .mac_overwrite      (mac_overwrite_1),
        .mac_overwrite_data (mac_overwrite_data_1),
        .mac_accumulator    (mac_acc_1),
        .data_out           (out_1),
        .data_out_valid     (out_valid_1),
        .data_out_ready     (1'b1)
`ifdef FIXED_MAC_DOT_SEQ_BIAS_EN
        ,
        .bias               (bias_1)
`endif
    );

    always #5 core_clk = ~core_clk;

    always @(posedge core_clk) cyc <= cyc + 1;

    // Behavioural MACs: overwrite wins over an accumulate in the same cycle.
    always @(posedge core_clk) begin
        if (mac_overwrite) begin
            mac_accumulator <= mac_overwrite_data;
        end else if (mac_in_valid && mac_in_ready) begin
            mac_accumulator <= mac_accumulator + DW'(mac_a * mac_b);
            mac_hs <= mac_hs + 1;
        end
        if (mac_overwrite_1) begin
            mac_acc_1 <= mac_overwrite_data_1;
        end else if (mac_in_valid_1) begin
            mac_acc_1 <= mac_acc_1 + DW'(mac_a_1 * mac_b_1);
            mac_hs_1 <= mac_hs_1 + 1;
        end
    end

    // Scoreboard: each accepted result pops the oldest expected value.
    always @(negedge core_clk) begin
        if (resetn) begin
            if (mac_overwrite) ovw_q.push_back(cyc);
            if (data_out_valid && !prev_valid) rise_q.push_back(cyc);
            if (data_out_valid && data_out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("[TB] FAIL scoreboard_unexpected: got data_out=%0h with no result due", data_out);
                end else begin
                    sb_exp = exp_q.pop_front();
                    if (data_out !== sb_exp) begin
                        failures++;
                        $display("[TB] FAIL scoreboard_result: got %0h expected %0h", data_out, sb_exp);
                    end
                end
                out_count++;
            end
        end
        prev_valid = data_out_valid;
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "[TB] watchdog");
    end

    task automatic stream_ops(input int n, input bit push, input bit gaps,
                              input int rdy_lo_start, input int rdy_lo_len);
        int i = 0;
        int t = 0;
        int vec_pushed = 0;
        logic [DW-1:0] acc;
        @(posedge core_clk);
        #1;
        while (i < n && t < 400) begin
            if (push && (i % VL == 0) && (i / VL == vec_pushed)) begin
                acc = bias_val;
                for (int k = 0; k < VL; k++) acc = acc + DW'(op_a[i+k] * op_b[i+k]);
                exp_q.push_back(acc);
                vec_pushed++;
            end
            data_in_a     = op_a[i];
            data_in_b     = op_b[i];
            data_in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            mac_in_ready  = !(t >= rdy_lo_start && t < rdy_lo_start + rdy_lo_len);
            @(negedge core_clk);
            if (data_in_valid && data_in_ready) begin
                hs_cyc[i] = cyc;
                i++;
            end
            @(posedge core_clk);
            #1;
            t++;
        end
        data_in_valid = 1'b0;
        data_in_a     = '0;
        data_in_b     = '0;
        mac_in_ready  = 1'b1;
        checks++;
        if (i != n) begin
            failures++;
            $display("[TB] FAIL stream_timeout: got %0d handshakes expected %0d", i, n);
        end
    endtask

    task automatic wait_outputs(input int target);
        int t = 0;
        while (out_count < target && t < 200) begin
            @(negedge core_clk);
            t++;
        end
        checks++;
        if (out_count < target) begin
            failures++;
            $display("[TB] FAIL output_timeout: got %0d results expected %0d", out_count, target);
        end
        @(posedge core_clk);
        #1;
    endtask

    task automatic load_basic_vector(input int base);
        for (int k = 0; k < VL; k++) begin
            op_a[base+k] = DW'(k + 1);
            op_b[base+k] = DW'(k + 5);
        end
    endtask

    task automatic test_reset();
        resetn        = 1'b0;
        data_in_valid = 1'b1;
        data_in_a     = 16'h1234;
        data_in_b     = 16'h5678;
        repeat (3) @(negedge core_clk);
        checks += 8;
        if (data_out !== '0) begin failures++; $display("[TB] FAIL reset_data_out: got %0h expected 0", data_out); end
        if (data_out_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid: got %b expected 0", data_out_valid); end
        if (mac_overwrite !== 1'b1) begin failures++; $display("[TB] FAIL reset_overwrite: got %b expected 1", mac_overwrite); end
        if (mac_overwrite_data !== '0) begin failures++; $display("[TB] FAIL reset_overwrite_data: got %0h expected 0", mac_overwrite_data); end
        if (mac_in_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_mac_in_valid: got %b expected 0", mac_in_valid); end
        if (data_in_ready !== 1'b0) begin failures++; $display("[TB] FAIL reset_in_ready: got %b expected 0", data_in_ready); end
        if (mac_a !== '0) begin failures++; $display("[TB] FAIL reset_mac_a: got %0h expected 0", mac_a); end
        if (mac_b !== '0) begin failures++; $display("[TB] FAIL reset_mac_b: got %0h expected 0", mac_b); end
        @(posedge core_clk);
        #1;
        resetn        = 1'b1;
        data_in_valid = 1'b0;
        @(negedge core_clk);
        checks++;
        if (mac_overwrite !== 1'b1) begin failures++; $display("[TB] FAIL release_clear: got overwrite=%b expected 1", mac_overwrite); end
        @(negedge core_clk);
        checks++;
        if (data_in_ready !== 1'b1 || mac_overwrite !== 1'b0) begin
            failures++;
            $display("[TB] FAIL release_stream: got ready=%b overwrite=%b expected 1/0", data_in_ready, mac_overwrite);
        end
    endtask

    task automatic test_back_to_back();
        int base = out_count;
        int n_between = 0;
        int n_inside = 0;
        load_basic_vector(0);
        for (int k = 0; k < VL; k++) begin
            op_a[VL+k] = DW'(1);
            op_b[VL+k] = DW'(2);
        end
        rise_q.delete();
        ovw_q.delete();
        data_out_ready = 1'b1;
        stream_ops(2 * VL, 1'b1, 1'b0, 0, 0);
        wait_outputs(base + 2);
        foreach (ovw_q[k]) begin
            if (ovw_q[k] > hs_cyc[3] && ovw_q[k] < hs_cyc[4]) n_between++;
            if (ovw_q[k] > hs_cyc[0] && ovw_q[k] < hs_cyc[3]) n_inside++;
        end
        checks += 5;
        if (hs_cyc[3] - hs_cyc[0] !== 3) begin failures++; $display("[TB] FAIL b2b_stream_len: got %0d expected 3", hs_cyc[3] - hs_cyc[0]); end
        if (hs_cyc[4] - hs_cyc[0] !== 7) begin failures++; $display("[TB] FAIL b2b_period: got %0d expected 7", hs_cyc[4] - hs_cyc[0]); end
        if (rise_q.size() < 2 || rise_q[0] !== hs_cyc[3] + 2) begin
            failures++;
            $display("[TB] FAIL b2b_latency1: got rises=%0d first=%0d expected %0d", rise_q.size(), (rise_q.size() > 0) ? rise_q[0] : -1, hs_cyc[3] + 2);
        end else if (rise_q[1] !== hs_cyc[7] + 2) begin
            failures++;
            $display("[TB] FAIL b2b_latency2: got %0d expected %0d", rise_q[1], hs_cyc[7] + 2);
        end
        if (n_between !== 1) begin failures++; $display("[TB] FAIL b2b_overwrite_between: got %0d pulses expected 1", n_between); end
        if (n_inside !== 0) begin failures++; $display("[TB] FAIL b2b_overwrite_inside: got %0d pulses expected 0", n_inside); end
    endtask

    task automatic test_gaps();
        int base = out_count;
        int hs0 = mac_hs;
        load_basic_vector(0);
        stream_ops(VL, 1'b1, 1'b1, 2, 3);
        wait_outputs(base + 1);
        checks++;
        if (mac_hs - hs0 !== VL) begin
            failures++;
            $display("[TB] FAIL gaps_mac_handshakes: got %0d expected %0d", mac_hs - hs0, VL);
        end
    endtask

    task automatic test_out_stall();
        int base = out_count;
        int hs0;
        int t = 0;
        logic [DW-1:0] stall_exp;
        load_basic_vector(0);
        stall_exp = DW'(70) + bias_val;
        data_out_ready = 1'b0;
        stream_ops(VL, 1'b1, 1'b0, 0, 0);
        while (!data_out_valid && t < 20) begin
            @(negedge core_clk);
            t++;
        end
        checks++;
        if (data_out_valid !== 1'b1) begin failures++; $display("[TB] FAIL stall_valid_timeout: got %b expected 1", data_out_valid); end
        hs0 = mac_hs;
        data_in_valid = 1'b1;
        data_in_a     = 16'd9;
        data_in_b     = 16'd9;
        for (int k = 0; k < 5; k++) begin
            @(negedge core_clk);
            checks++;
            if (data_out !== stall_exp || data_out_valid !== 1'b1 || data_in_ready !== 1'b0 || mac_in_valid !== 1'b0) begin
                failures++;
                $display("[TB] FAIL stall_hold: got out=%0h v=%b in_ready=%b mac_v=%b expected %0h/1/0/0",
                         data_out, data_out_valid, data_in_ready, mac_in_valid, stall_exp);
            end
        end
        @(posedge core_clk);
        #1;
        data_in_valid = 1'b0;
        checks++;
        if (mac_hs !== hs0) begin failures++; $display("[TB] FAIL stall_mac_quiet: got %0d handshakes expected %0d", mac_hs - hs0, 0); end
        data_out_ready = 1'b1;
        wait_outputs(base + 1);
    endtask

    task automatic test_overflow();
        int base = out_count;
        for (int k = 0; k < VL; k++) begin
            op_a[k] = 16'h7FFF;
            op_b[k] = 16'h0002;
        end
        stream_ops(VL, 1'b1, 1'b0, 0, 0);
        wait_outputs(base + 1);
    endtask

    task automatic test_vector_len1();
        int t = 0;
        int hcyc = -1;
        int vcyc = -1;
        int hs0 = mac_hs_1;
        @(posedge core_clk);
        #1;
        in_a_1     = 16'd3;
        in_b_1     = 16'd9;
        in_valid_1 = 1'b1;
        while (hcyc < 0 && t < 20) begin
            @(negedge core_clk);
            if (in_valid_1 && in_ready_1) hcyc = cyc;
            @(posedge core_clk);
            #1;
            t++;
        end
        in_valid_1 = 1'b0;
        t = 0;
        while (vcyc < 0 && t < 20) begin
            @(negedge core_clk);
            if (out_valid_1) vcyc = cyc;
            t++;
        end
        checks += 4;
        if (hcyc < 0) begin failures++; $display("[TB] FAIL len1_handshake: got none expected one"); end
        if (vcyc - hcyc !== 2) begin failures++; $display("[TB] FAIL len1_latency: got %0d expected 2", vcyc - hcyc); end
        if (out_1 !== 16'd27) begin failures++; $display("[TB] FAIL len1_result: got %0d expected 27", out_1); end
        if (mac_hs_1 - hs0 !== 1) begin failures++; $display("[TB] FAIL len1_mac_handshakes: got %0d expected 1", mac_hs_1 - hs0); end
        @(posedge core_clk);
        #1;
    endtask

    task automatic test_reset_mid();
        int base;
        load_basic_vector(0);
        stream_ops(2, 1'b0, 1'b0, 0, 0);
        resetn = 1'b0;
        @(negedge core_clk);
        checks += 4;
        if (data_out !== '0) begin failures++; $display("[TB] FAIL midreset_data_out: got %0h expected 0", data_out); end
        if (data_out_valid !== 1'b0) begin failures++; $display("[TB] FAIL midreset_valid: got %b expected 0", data_out_valid); end
        if (mac_overwrite !== 1'b1) begin failures++; $display("[TB] FAIL midreset_clear: got overwrite=%b expected 1", mac_overwrite); end
        if (data_in_ready !== 1'b0) begin failures++; $display("[TB] FAIL midreset_in_ready: got %b expected 0", data_in_ready); end
        @(posedge core_clk);
        #1;
        resetn = 1'b1;
        base = out_count;
        stream_ops(VL, 1'b1, 1'b0, 0, 0);
        wait_outputs(base + 1);
    endtask

`ifdef FIXED_MAC_DOT_SEQ_BIAS_EN
    task automatic test_bias();
        int base = out_count;
        bias_val = 16'd100;
        load_basic_vector(0);
        stream_ops(VL, 1'b1, 1'b0, 0, 0);
        wait_outputs(base + 1);
        bias_val = '0;
    endtask
`endif

    initial begin
        test_reset();
        test_back_to_back();
        test_gaps();
        test_out_stall();
        test_overflow();
        test_vector_len1();
        test_reset_mid();
`ifdef FIXED_MAC_DOT_SEQ_BIAS_EN
        test_bias();
`endif
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("[TB] FAIL scoreboard_leftover: got %0d pending results expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fixed_mac_dot_seq.md
Name: fixed_mac_dot_seq

Overview:
- Initiator-side sequencer for the team's fixed-point MAC accumulator interface.
- Accepts a stream of (a, b) operand pairs, clears the MAC before each vector and forwards VECTOR_LEN operand pairs over the MAC valid/ready port.
- Waits one cycle for the MAC's registered accumulator to settle, then presents the dot product on a registered valid/ready output.
- Sits between an operand fetch unit and one MAC instance.

Parameters:
- DATA_WIDTH, 16, width of operands, MAC accumulator and result.
- VECTOR_LEN, 4, operand pairs per dot product; must be at least 1.

Ports:
- core_clk  input  1  clock.
- resetn  input  1  asynchronous active-low reset.
- data_in_a  input  DATA_WIDTH  operand a.
- data_in_b  input  DATA_WIDTH  operand b.
- data_in_valid  input  1  operand pair valid.
- data_in_ready  output  1  operand pair accepted.
- mac_a  output  DATA_WIDTH  to MAC a.
- mac_b  output  DATA_WIDTH  to MAC b.
- mac_in_valid  output  1  to MAC in_valid.
- mac_in_ready  input  1  from MAC in_ready.
- mac_overwrite  output  1  to MAC overwrite.
- mac_overwrite_data  output  DATA_WIDTH  to MAC overwrite_data.
- mac_accumulator  input  DATA_WIDTH  from MAC accumulator.
- data_out  output  DATA_WIDTH  dot-product result (registered).
- data_out_valid  output  1  result valid (registered).
- data_out_ready  input  1  downstream accepts result.

Behaviour:
- Clock and reset are fixed: one clock, core_clk; reset is resetn, asynchronous and active-low.
- MAC contract:
  - The accumulator updates on the clock edge that ends a cycle in which mac_in_valid and mac_in_ready are both high.
  - mac_overwrite has priority over that update.
  - Arithmetic is modulo 2^DATA_WIDTH. This block performs no arithmetic; data_out is the MAC accumulator value, bit-exact.
- FSM states: CLEAR, STREAM, SETTLE, OUT. Reset state is CLEAR.
- CLEAR (1 cycle):
  - mac_overwrite=1, mac_overwrite_data=0, mac_in_valid=0, data_in_ready=0.
  - Count is cleared to 0. Next state is STREAM.
- STREAM:
  - Combinational pass-through: mac_a=data_in_a, mac_b=data_in_b, mac_in_valid=data_in_valid, data_in_ready=mac_in_ready, mac_overwrite=0.
  - Count increments only on a handshake.
  - A handshake with count==VECTOR_LEN-1 moves to SETTLE.
  - Bubbles on either side are legal and do not change the count.
- SETTLE (1 cycle):
  - mac_in_valid=0, data_in_ready=0.
  - On the clock edge that ends SETTLE, data_out<=mac_accumulator and data_out_valid<=1. Next state is OUT.
- OUT:
  - data_out and data_out_valid are held stable; data_in_ready=0, mac_in_valid=0.
  - On data_out_valid && data_out_ready, data_out_valid<=0 and next state is CLEAR. data_out keeps its last value.
- Latency and throughput:
  - data_out_valid rises 2 cycles after the final operand handshake.
  - Minimum period is VECTOR_LEN+3 cycles per vector (CLEAR, VECTOR_LEN handshakes, SETTLE, OUT).
- mac_a and mac_b drive 0 outside STREAM.
- Count width is max(1, $clog2(VECTOR_LEN)). VECTOR_LEN=1 goes STREAM to SETTLE on the first handshake.
- Reset values:
  - state=CLEAR, count=0, data_out=0, data_out_valid=0.
  - Combinational outputs during reset follow the CLEAR state: mac_overwrite=1, mac_overwrite_data=0, mac_in_valid=0, data_in_ready=0, mac_a=0, mac_b=0.
- Reset mid-operation discards the partial vector. After reset release the first cycle is CLEAR.
- Simultaneous events:
  - OUT accept and new data_in_valid: the operand is not taken until STREAM, because CLEAR always intervenes.
  - data_out_ready asserted early (outside OUT) has no effect.

Optional Feature:
- Macro FIXED_MAC_DOT_SEQ_BIAS_EN.
- With the macro defined:
  - Adds port bias, input, DATA_WIDTH.
  - In CLEAR, mac_overwrite_data=bias, so the result is bias plus the sum of a*b, mod 2^DATA_WIDTH.
  - bias is sampled only in the CLEAR cycle.
- Without the macro: there is no bias port and mac_overwrite_data=0.

Test Plan:
1. VECTOR_LEN=4, DATA_WIDTH=16, a={1,2,3,4}, b={5,6,7,8}, valid and ready held high -> data_out=70, valid 2 cycles after the 4th handshake; next vector starts 7 cycles after the first.
2. Back-to-back vectors, second is a={1,1,1,1}, b={2,2,2,2} -> second result is 8, not 78; mac_overwrite pulses exactly once per vector.
3. Vector of test 1 with random data_in_valid gaps and mac_in_ready low for 3 cycles -> still 70; count changes only on handshake; no operand lost or duplicated.
4. data_out_ready low for 5 cycles in OUT -> data_out=70 and data_out_valid=1 held; data_in_ready=0 and mac_in_valid=0 throughout.
5. Overflow case a=0x7FFF, b=2 four times -> data_out=0xFFF8. Separately, VECTOR_LEN=1, a=3, b=9 -> data_out=27.
6. Reset asserted after 2 handshakes -> data_out=0, data_out_valid=0, state is CLEAR; a fresh vector from test 1 gives 70. With FIXED_MAC_DOT_SEQ_BIAS_EN and bias=100, test 1 gives 170.
